// File: rtl/sbqm_beam_conditioner.sv
// -----------------------------------------------------------------------------
// sbqm_beam_conditioner
//
// Cleans up the raw front/back photo-beam signals at the queue entrance and
// turns completed beam passages into active-low, non-overlapping count pulses
// for the downstream person counter (back beam -> up count, front beam ->
// down count).
//
// Per beam: 2-flop synchroniser -> debounce counter -> 0->1 event detector ->
// pending bit. A shared pulse FSM serialises the pending events into pulses
// of PULSE_W low cycles, separated by at least one high gap cycle.
//
// Parameters:
//   DB_CYCLES    consecutive mismatching cycles needed to accept a level change
//   DB_W         debounce counter width (2**DB_W > DB_CYCLES)
//   PULSE_W      low time of each count pulse, in cycles (>= 1)
//   STUCK_CYCLES blocked duration that flags a stuck beam (stuck detector only)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   Reset         asynchronous active-high reset
//   back_beam_i   raw back beam, asynchronous, 0 = interrupted
//   front_beam_i  raw front beam, asynchronous, 0 = interrupted
//   up_count_o    active-low count-up pulse
//   down_count_o  active-low count-down pulse
//   both_evt_o    one-cycle high when both beams complete on the same edge
//   back_level_o  debounced back beam level
//   front_level_o debounced front beam level
//   stuck_o       high while a debounced beam has been 0 for STUCK_CYCLES
//
// Build option:
//   SBQM_BEAM_STUCK_DETECT_EN  when defined, adds the per-beam stuck counters;
//                              otherwise stuck_o is tied low.
// -----------------------------------------------------------------------------
module sbqm_beam_conditioner #(
  parameter int DB_CYCLES    = 1000,
  parameter int DB_W         = 10,
  parameter int PULSE_W      = 2,
  parameter int STUCK_CYCLES = 1 << 20
) (
  input  logic clk,
  input  logic Reset,
  input  logic back_beam_i,
  input  logic front_beam_i,
  output logic up_count_o,
  output logic down_count_o,
  output logic both_evt_o,
  output logic back_level_o,
  output logic front_level_o,
  output logic stuck_o
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam int              PC_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE_UP = 2'd1,
    S_PULSE_DN = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  // Channel index 0 = back beam, 1 = front beam.
  logic [1:0]      r_back_sync;
  logic [1:0]      r_front_sync;
  logic [1:0]      w_sync;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      r_lvl;
  logic [1:0]      r_lvl_d;
  logic [1:0]      w_rise;

  logic            r_pend_back;
  logic            r_pend_front;
  logic            w_both;
  logic            r_both;

  state_t          r_state;
  state_t          w_next;
  logic            w_clr_back;
  logic            w_clr_front;
  logic [PC_W-1:0] r_pcnt;
  logic            r_up;
  logic            r_dn;

  // ---- Stage: 2-flop synchronisers (idle level is 1 = beam clear) ----
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_back_sync  <= 2'b11;
      r_front_sync <= 2'b11;
    end else begin
      r_back_sync  <= {r_back_sync[0], back_beam_i};
      r_front_sync <= {r_front_sync[0], front_beam_i};
    end
  end

  assign w_sync = {r_front_sync[1], r_back_sync[1]};

  // ---- Stage: debounce and level history ----
  // The counter only runs while the synced value disagrees with the accepted
  // level; any agreement restarts the stability window from zero.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < 2; c++) r_db_cnt[c] <= '0;
      r_lvl   <= 2'b11;
      r_lvl_d <= 2'b11;
    end else begin
      r_lvl_d <= r_lvl;
      for (int c = 0; c < 2; c++) begin
        if (w_sync[c] == r_lvl[c]) begin
          r_db_cnt[c] <= '0;
        end else if (r_db_cnt[c] == DB_LAST) begin
          r_lvl[c]    <= w_sync[c];
          r_db_cnt[c] <= '0;
        end else begin
          r_db_cnt[c] <= r_db_cnt[c] + DB_W'(1);
        end
      end
    end
  end

  // A passage completes when the debounced level returns to 1.
  assign w_rise = r_lvl & ~r_lvl_d;

  // Two completions on the same edge with nothing in flight cancel out:
  // one person in, one person out, occupancy unchanged.
  assign w_both = w_rise[0] & w_rise[1] & (r_state == S_IDLE) &
                  ~r_pend_back & ~r_pend_front;

  // ---- Stage: pending event bits ----
  // An event that finds its own channel already pending is dropped; clearing
  // only happens on FSM entry, which requires the bit to be set.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_pend_back  <= 1'b0;
      r_pend_front <= 1'b0;
      r_both       <= 1'b0;
    end else begin
      r_both <= w_both;
      if (w_rise[0] && !r_pend_back && !w_both) r_pend_back <= 1'b1;
      else if (w_clr_back)                      r_pend_back <= 1'b0;
      if (w_rise[1] && !r_pend_front && !w_both) r_pend_front <= 1'b1;
      else if (w_clr_front)                      r_pend_front <= 1'b0;
    end
  end

  // ---- Stage: pulse FSM ----
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
      r_up    <= 1'b1;
      r_dn    <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_pcnt <= '0;
      else if (r_state == S_PULSE_UP || r_state == S_PULSE_DN)
        r_pcnt <= r_pcnt + PC_W'(1);
      // Outputs are registered from the next state so they change together
      // with the state register and can never both be low.
      r_up <= (w_next != S_PULSE_UP);
      r_dn <= (w_next != S_PULSE_DN);
    end
  end

  // The gap cycle may launch the next queued pulse directly, so back-to-back
  // pulses are separated by exactly one high cycle. Back has priority.
  always_comb begin
    w_next      = r_state;
    w_clr_back  = 1'b0;
    w_clr_front = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (r_pend_back) begin
          w_next     = S_PULSE_UP;
          w_clr_back = 1'b1;
        end else if (r_pend_front) begin
          w_next      = S_PULSE_DN;
          w_clr_front = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_PULSE_UP, S_PULSE_DN: begin
        if (r_pcnt == PC_LAST) w_next = S_GAP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign up_count_o    = r_up;
  assign down_count_o  = r_dn;
  assign both_evt_o    = r_both;
  assign back_level_o  = r_lvl[0];
  assign front_level_o = r_lvl[1];

`ifdef SBQM_BEAM_STUCK_DETECT_EN
  localparam int ST_W = ($clog2(STUCK_CYCLES + 1) > 21) ? $clog2(STUCK_CYCLES + 1) : 21;
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STUCK_CYCLES);

  logic [ST_W-1:0] r_stuck_cnt [2];

  // ---- Stage: stuck-beam counters (saturating while blocked) ----
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < 2; c++) r_stuck_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (r_lvl[c])                     r_stuck_cnt[c] <= '0;
        else if (r_stuck_cnt[c] != ST_MAX) r_stuck_cnt[c] <= r_stuck_cnt[c] + ST_W'(1);
      end
    end
  end

  assign stuck_o = (r_stuck_cnt[0] == ST_MAX) | (r_stuck_cnt[1] == ST_MAX);
`else
  logic w_unused_stuck;
  assign w_unused_stuck = (STUCK_CYCLES != 0);
  assign stuck_o        = 1'b0;
`endif

endmodule

// File: tb/tb_sbqm_beam_conditioner.sv
module tb_sbqm_beam_conditioner;

  localparam int DB_CYCLES    = 4;
  localparam int DB_W         = 3;
  localparam int PULSE_W      = 2;
  localparam int STUCK_CYCLES = 16;

  logic clk = 1'b0;
  logic Reset;
  logic back_beam_i;
  logic front_beam_i;
  logic up_count_o;
  logic down_count_o;
  logic both_evt_o;
  logic back_level_o;
  logic front_level_o;
  logic stuck_o;

  sbqm_beam_conditioner #(
    .DB_CYCLES   (DB_CYCLES),
    .DB_W        (DB_W),
    .PULSE_W     (PULSE_W),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .back_beam_i  (back_beam_i),
    .front_beam_i (front_beam_i),
    .up_count_o   (up_count_o),
    .down_count_o (down_count_o),
    .both_evt_o   (both_evt_o),
    .back_level_o (back_level_o),
    .front_level_o(front_level_o),
    .stuck_o      (stuck_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observation counters filled by run().
  int n_up, n_dn, n_both, n_ovl, n_stuck;
  int first_up, first_dn, first_both, first_stuck;

  typedef struct {
    logic       back;
    logic       front;
    logic [4:0] exp;   // {up, down, both, back_level, front_level}
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the beams for n cycles (each low for the first *_low cycles) and
  // record what the outputs do. Starts and ends on a falling clock edge.
  task automatic run(input int n, input int b_low, input int f_low);
    n_up = 0; n_dn = 0; n_both = 0; n_ovl = 0; n_stuck = 0;
    first_up = -1; first_dn = -1; first_both = -1; first_stuck = -1;
    for (int s = 0; s < n; s++) begin
      back_beam_i  = (s < b_low) ? 1'b0 : 1'b1;
      front_beam_i = (s < f_low) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!up_count_o) begin n_up++; if (first_up < 0) first_up = s; end
      if (!down_count_o) begin n_dn++; if (first_dn < 0) first_dn = s; end
      if (both_evt_o) begin n_both++; if (first_both < 0) first_both = s; end
      if (!up_count_o && !down_count_o) n_ovl++;
      if (stuck_o) begin n_stuck++; if (first_stuck < 0) first_stuck = s; end
    end
  endtask

  initial begin
    vec_t v;

    // Back passage: low for 10 cycles; level falls 5 cycles after the input,
    // rises at step 15, pending at 16, up pulse low at steps 17 and 18.
    for (int i = 0; i < 24; i++) begin
      v.back  = (i < 10) ? 1'b0 : 1'b1;
      v.front = 1'b1;
      v.exp   = {(i == 17 || i == 18) ? 1'b0 : 1'b1, 1'b1, 1'b0,
                 (i >= 5 && i <= 14) ? 1'b0 : 1'b1, 1'b1};
      tbl.push_back(v);
    end
    // Bounce: front toggles every 2 cycles for 20 cycles, then steady 1.
    for (int i = 0; i < 28; i++) begin
      v.back  = 1'b1;
      v.front = (i < 20 && ((i / 2) % 2 == 0)) ? 1'b0 : 1'b1;
      v.exp   = 5'b11011;
      tbl.push_back(v);
    end

    // Reset with beams blocked.
    Reset        = 1'b1;
    back_beam_i  = 1'b0;
    front_beam_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_up",    {31'b0, up_count_o},    32'd1);
    check("rst_dn",    {31'b0, down_count_o},  32'd1);
    check("rst_both",  {31'b0, both_evt_o},    32'd0);
    check("rst_blvl",  {31'b0, back_level_o},  32'd1);
    check("rst_flvl",  {31'b0, front_level_o}, 32'd1);
    check("rst_stuck", {31'b0, stuck_o},       32'd0);

    back_beam_i  = 1'b1;
    front_beam_i = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    run(12, 0, 0);
    check("post_rst_up",   n_up,   0);
    check("post_rst_dn",   n_dn,   0);
    check("post_rst_both", n_both, 0);

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      back_beam_i  = tbl[i].back;
      front_beam_i = tbl[i].front;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {27'b0, up_count_o, down_count_o, both_evt_o, back_level_o, front_level_o},
            {27'b0, tbl[i].exp});
    end

    // Simultaneous passage: both levels rise at step 15, both_evt at step 16.
    run(26, 10, 10);
    check("sim_both_cnt",   n_both,     1);
    check("sim_both_at",    first_both, 16);
    check("sim_up",         n_up,       0);
    check("sim_dn",         n_dn,       0);

    // Staggered: front rises one cycle after back.
    run(28, 10, 11);
    check("stag_up_cnt",  n_up,     2);
    check("stag_dn_cnt",  n_dn,     2);
    check("stag_up_at",   first_up, 17);
    check("stag_dn_at",   first_dn, 20);
    check("stag_overlap", n_ovl,    0);
    check("stag_both",    n_both,   0);

    // Reset during the up pulse with a down event queued behind it.
    run(18, 10, 11);
    check("abort_pre_up", {31'b0, up_count_o}, 32'd0);
    #2 Reset = 1'b1;
    #1;
    check("abort_async_up", {31'b0, up_count_o},   32'd1);
    check("abort_async_dn", {31'b0, down_count_o}, 32'd1);
    @(negedge clk);
    Reset = 1'b0;
    run(20, 0, 0);
    check("abort_no_up", n_up, 0);
    check("abort_no_dn", n_dn, 0);

    // Stuck back beam: level low from step 5, saturates at step 21,
    // release at 30 -> level 1 at step 35, stuck clears at step 36.
    run(45, 30, 0);
`ifdef SBQM_BEAM_STUCK_DETECT_EN
    check("stuck_cycles", n_stuck,     15);
    check("stuck_first",  first_stuck, 21);
`else
    check("stuck_cycles", n_stuck, 0);
`endif
    check("stuck_up_cnt", n_up, 2);
    check("stuck_dn_cnt", n_dn, 0);
    check("stuck_final",  {31'b0, stuck_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
